cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_unit_pkg.sv | 52 +++++
 rtl/cp0_unit.sv | 93 +++++++++
 tb/tb_cp0_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_unit_pkg.sv
// Shared heads for the CP0 unit: register addresses, exception codes, PRId value
// and SR/Cause field positions. Consumers build with or without CP0_BD_EN.
package cp0_unit_pkg;

    localparam int DATA_W = 32;

    // CP0 register addresses
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // Exception codes carried down the E/M chain
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [DATA_W-1:0] PRID_VAL = 32'h0000_7C07;

    // Field bit positions
    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LO      = 10;
    localparam int SR_IM_HI      = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_BD_BIT  = 31;

    localparam logic [DATA_W-1:0] SR_WMASK = 32'h0000_FC03;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc;
    } cause_t;

    // Exception return addresses are always word aligned
    function automatic logic [DATA_W-1:0] epc_align(input logic [DATA_W-1:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// CP0 coprocessor: SR/Cause/EPC/PRId, interrupt and exception entry, eret.
// Define CP0_BD_EN to implement Cause.BD and the delay-slot EPC adjustment.
module cp0_unit
    import cp0_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        a1,
    input  logic [4:0]        a2,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    input  logic [DATA_W-1:0] pc_m,
    input  logic              exc_vld,
    input  logic [4:0]        exccode_m,
    input  logic              bd_m,
    input  logic [5:0]        hwint,
    input  logic              eret,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] epc_out,
    output logic              take
);

    sr_t               sr;
    cause_t            cause;
    logic [DATA_W-1:0] epc;

    logic              int_pend;
    logic              bd_eff;
    logic [DATA_W-1:0] epc_entry;
    logic [DATA_W-1:0] sr_word;
    logic [DATA_W-1:0] cause_word;

`ifdef CP0_BD_EN
    assign bd_eff    = bd_m;
    assign epc_entry = epc_align(bd_m ? pc_m - 32'd4 : pc_m);
`else
    logic unused_bd_m;
    assign unused_bd_m = bd_m;
    assign bd_eff      = 1'b0;
    assign epc_entry   = epc_align(pc_m);
`endif

    // Interrupts see the registered IP, so a new hwint takes one cycle to act
    assign int_pend = (|(cause.ip & sr.im)) & sr.ie & ~sr.exl;
    assign take     = ~reset & (int_pend | (exc_vld & ~sr.exl));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr    <= '0;
            cause <= '0;
            epc   <= '0;
        end else begin
            cause.ip <= hwint;
            if (take) begin
                sr.exl    <= 1'b1;
                cause.bd  <= bd_eff;
                cause.exc <= int_pend ? EXC_INT : exccode_m;
                epc       <= epc_entry;
            end else begin
                if (we && (a2 == CP0_SR)) begin
                    sr.im  <= din[SR_IM_HI:SR_IM_LO];
                    sr.exl <= din[SR_EXL_BIT];
                    sr.ie  <= din[SR_IE_BIT];
                end
                if (we && (a2 == CP0_EPC)) begin
                    epc <= din;
                end
                // eret wins over an mtc0 that would set EXL in the same cycle
                if (eret) begin
                    sr.exl <= 1'b0;
                end
            end
        end
    end

    assign sr_word    = {16'b0, sr.im, 8'b0, sr.exl, sr.ie};
    assign cause_word = {cause.bd, 15'b0, cause.ip, 3'b0, cause.exc, 2'b0};

    always_comb begin
        rdata = '0;
        case (a1)
            CP0_SR:    rdata = sr_word;
            CP0_CAUSE: rdata = cause_word;
            CP0_EPC:   rdata = epc;
            CP0_PRID:  rdata = PRID_VAL;
            default:   rdata = '0;
        endcase
    end

    // Forward an in-flight EPC write so an eret in the same cycle sees it
    assign epc_out = (we && (a2 == CP0_EPC)) ? din : epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Randomised bench for cp0_unit with a word-level reference model and
// directed literal checks for the key exception/interrupt scenarios.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1, a2;
    logic [31:0] din, pc_m;
    logic        we, exc_vld, bd_m, eret;
    logic [4:0]  exccode_m;
    logic [5:0]  hwint;
    logic [31:0] rdata, epc_out;
    logic        take;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_sr, m_cause, m_epc;

`ifdef CP0_BD_EN
    localparam bit BD_EN = 1'b1;
`else
    localparam bit BD_EN = 1'b0;
`endif

    cp0_unit dut (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din), .we(we),
        .pc_m(pc_m), .exc_vld(exc_vld), .exccode_m(exccode_m), .bd_m(bd_m),
        .hwint(hwint), .eret(eret), .rdata(rdata), .epc_out(epc_out), .take(take)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_int_pend();
        return ((m_cause[15:10] & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic bit m_take();
        if (reset) return 1'b0;
        return m_int_pend() || (exc_vld && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_7C07;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_epc_out();
        return (we && a2 == 5'd14) ? din : m_epc;
    endfunction

    task automatic model_clear();
        m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
    endtask

    // Advance one clock: model next state from current inputs, then land 1 unit after the edge
    task automatic step();
        logic [31:0] ns, nc, ne;
        logic        tk, ip;
        tk = m_take();
        ip = m_int_pend();
        ns = m_sr;
        ne = m_epc;
        nc = (m_cause & ~32'h0000_FC00) | ({26'b0, hwint} << 10);
        if (tk) begin
            ns = m_sr | 32'h2;
            ne = ((BD_EN && bd_m) ? pc_m - 32'd4 : pc_m) & ~32'h3;
            nc = (nc & 32'h0000_FC00) | (ip ? 32'h0 : ({27'b0, exccode_m} << 2))
                 | ((BD_EN && bd_m) ? 32'h8000_0000 : 32'h0);
        end else begin
            if (we && a2 == 5'd12) ns = din & 32'h0000_FC03;
            if (we && a2 == 5'd14) ne = din;
            if (eret) ns = ns & ~32'h2;
        end
        if (reset) begin
            ns = 32'h0; nc = 32'h0; ne = 32'h0;
        end
        @(posedge clk);
        m_sr = ns; m_cause = nc; m_epc = ne;
        #1;
    endtask

    task automatic idle();
        we = 1'b0; a2 = 5'd0; din = 32'h0; exc_vld = 1'b0; exccode_m = 5'd0;
        pc_m = 32'h0; bd_m = 1'b0; eret = 1'b0; hwint = 6'd0; a1 = 5'd0;
    endtask

    task automatic read_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
        a1 = a;
        #1;
        chk(nm, rdata, exp);
        chk({nm, "_model"}, m_read(a), exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("take", {31'b0, take}, {31'b0, m_take()});
            chk("rdata", rdata, m_read(a1));
            chk("epc_out", epc_out, m_epc_out());
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        read_chk("rst_sr", 5'd12, 32'h0);
        read_chk("rst_prid", 5'd15, 32'h0000_7C07);
        chk_en = 1'b1;

        // Overflow exception, not in a delay slot
        exc_vld = 1'b1; exccode_m = 5'd12; pc_m = 32'h3010; bd_m = 1'b0;
        #1;
        chk("ov_take", {31'b0, take}, 32'h1);
        step();
        exc_vld = 1'b0;
        read_chk("ov_epc", 5'd14, 32'h3010);
        read_chk("ov_cause", 5'd13, 32'h30);
        read_chk("ov_sr", 5'd12, 32'h2);

        // Reset mid-handler, asserted away from the clock edge
        chk_en = 1'b0;
        step();
        #1;
        exc_vld = 1'b1;
        reset = 1'b1;
        model_clear();
        #1;
        chk("rst_mid_take", {31'b0, take}, 32'h0);
        a1 = 5'd12; #1 chk("rst_mid_sr", rdata, 32'h0);
        a1 = 5'd13; #1 chk("rst_mid_cause", rdata, 32'h0);
        a1 = 5'd14; #1 chk("rst_mid_epc", rdata, 32'h0);
        a1 = 5'd15; #1 chk("rst_mid_prid", rdata, 32'h0000_7C07);
        step();
        reset = 1'b0;
        idle();
        chk_en = 1'b1;
        read_chk("post_rst_sr", 5'd12, 32'h0);

        // AdEL in a delay slot
        exc_vld = 1'b1; exccode_m = 5'd4; pc_m = 32'h3024; bd_m = 1'b1;
        step();
        idle();
        read_chk("bd_epc", 5'd14, BD_EN ? 32'h3020 : 32'h3024);
        read_chk("bd_cause", 5'd13, BD_EN ? 32'h8000_0010 : 32'h10);
        eret = 1'b1;
        step();
        idle();
        read_chk("bd_eret_sr", 5'd12, 32'h0);

        // Interrupt line 0 enabled; exception alongside must not change ExcCode
        we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
        step();
        idle();
        hwint = 6'b000001;
        #1;
        chk("int_latency", {31'b0, take}, 32'h0);
        step();
        exc_vld = 1'b1; exccode_m = 5'd12; pc_m = 32'h3050;
        #1;
        chk("int_take", {31'b0, take}, 32'h1);
        step();
        exc_vld = 1'b0;
        read_chk("int_cause", 5'd13, 32'h0000_0400);
        read_chk("int_epc", 5'd14, 32'h3050);
        read_chk("int_sr", 5'd12, 32'h0000_0403);

        // mtc0 EPC together with eret: forwarded immediately
        hwint = 6'd0;
        we = 1'b1; a2 = 5'd14; din = 32'h3100; eret = 1'b1;
        #1;
        chk("fwd_epc_out", epc_out, 32'h3100);
        step();
        idle();
        read_chk("fwd_sr", 5'd12, 32'h0000_0401);
        read_chk("fwd_epc", 5'd14, 32'h3100);

        // Nested exception while EXL is set is dropped
        exc_vld = 1'b1; exccode_m = 5'd10; pc_m = 32'h4000;
        step();
        exc_vld = 1'b1; exccode_m = 5'd5; pc_m = 32'h5000;
        #1;
        chk("nest_take", {31'b0, take}, 32'h0);
        step();
        idle();
        read_chk("nest_epc", 5'd14, 32'h4000);
        read_chk("nest_cause", 5'd13, 32'h28);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [4:0] codes [5];
            logic [4:0] addrs [5];
            codes = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
            addrs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'($urandom_range(0, 31))};
            if ($urandom_range(0, 79) == 0) begin
                reset = 1'b1;
                model_clear();
            end else begin
                reset = 1'b0;
            end
            a1        = addrs[$urandom_range(0, 4)];
            a2        = addrs[$urandom_range(0, 4)];
            we        = ($urandom_range(0, 3) == 0);
            din       = $urandom();
            pc_m      = $urandom();
            exc_vld   = ($urandom_range(0, 4) == 0);
            exccode_m = codes[$urandom_range(0, 4)];
            bd_m      = 1'($urandom_range(0, 1));
            eret      = ($urandom_range(0, 7) == 0);
            hwint     = ($urandom_range(0, 5) == 0) ? 6'($urandom()) : 6'd0;
            step();
        end
        reset = 1'b0;
        idle();
        step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
